// File: rtl/uart_hex_tx.sv
// ASCII hex formatter feeding a byte-wide UART TX handshake (data/valid/ready).
// Define UART_HEX_PREFIX_EN to begin every message with "0x".
module uart_hex_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned UPPERCASE  = 1,
  parameter int unsigned NEWLINE    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int unsigned NDIG  = DATA_WIDTH / 4;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
`ifdef UART_HEX_PREFIX_EN
  localparam logic [2:0] ST_PFX0  = 3'd1;
  localparam logic [2:0] ST_PFXX  = 3'd2;
`endif
  localparam logic [2:0] ST_DIGIT = 3'd3;
  localparam logic [2:0] ST_CR    = 3'd4;
  localparam logic [2:0] ST_LF    = 3'd5;
  localparam logic [2:0] ST_FIN   = 3'd6;

  logic [2:0]            state_reg, state_next;
  logic [DATA_WIDTH-1:0] value_reg, value_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [CNT_W-1:0]      cnt_inc;
  logic [7:0]            tx_data_reg, tx_data_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  xfer;
  logic [3:0]            nib [NDIG];

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] alpha_base;
    alpha_base = (UPPERCASE != 0) ? 8'h41 : 8'h61;
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return alpha_base + {4'h0, n} - 8'd10;
  endfunction

  // nib[0] is the most significant nibble, so the counter walks MSN first
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_nib
      assign nib[gi] = value_reg[DATA_WIDTH-1-4*gi -: 4];
    end
  endgenerate

  assign cnt_inc = cnt_reg + 1'b1;
  assign xfer    = tx_valid_reg && tx_ready;

  always_comb begin
    state_next    = state_reg;
    value_next    = value_reg;
    cnt_next      = cnt_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          value_next    = value;
          cnt_next      = '0;
          busy_next     = 1'b1;
          tx_valid_next = 1'b1;
`ifdef UART_HEX_PREFIX_EN
          state_next    = ST_PFX0;
          tx_data_next  = 8'h30;
`else
          state_next    = ST_DIGIT;
          tx_data_next  = hex_char(value[DATA_WIDTH-1 -: 4]);
`endif
        end
      end
`ifdef UART_HEX_PREFIX_EN
      ST_PFX0: begin
        if (xfer) begin
          state_next   = ST_PFXX;
          tx_data_next = 8'h78;
        end
      end
      ST_PFXX: begin
        if (xfer) begin
          state_next   = ST_DIGIT;
          tx_data_next = hex_char(nib[0]);
        end
      end
`endif
      ST_DIGIT: begin
        if (xfer) begin
          if (cnt_reg == CNT_LAST) begin
            if (NEWLINE != 0) begin
              state_next   = ST_CR;
              tx_data_next = 8'h0D;
            end else begin
              state_next    = ST_FIN;
              tx_data_next  = 8'h00;
              tx_valid_next = 1'b0;
              done_next     = 1'b1;
            end
          end else begin
            cnt_next     = cnt_inc;
            tx_data_next = hex_char(nib[cnt_inc]);
          end
        end
      end
      ST_CR: begin
        if (xfer) begin
          state_next   = ST_LF;
          tx_data_next = 8'h0A;
        end
      end
      ST_LF: begin
        if (xfer) begin
          state_next    = ST_FIN;
          tx_data_next  = 8'h00;
          tx_valid_next = 1'b0;
          done_next     = 1'b1;
        end
      end
      ST_FIN: begin
        // done is high during this state; busy drops as we return to IDLE
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next    = ST_IDLE;
        busy_next     = 1'b0;
        tx_valid_next = 1'b0;
        tx_data_next  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      value_reg    <= '0;
      cnt_reg      <= '0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      value_reg    <= value_next;
      cnt_reg      <= cnt_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Randomized bench for uart_hex_tx: message-level reference model plus literal pins.
`timescale 1ns/1ps
module tb_uart_hex_tx;

  localparam int NDIG = 8;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        tx_ready = 1'b0;
  logic        busy, done, tx_valid;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  uart_hex_tx #(.DATA_WIDTH(32), .UPPERCASE(1), .NEWLINE(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .start(start),
    .busy(busy), .done(done), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole message as the spec words it: optional "0x", NDIG hex digits MSN first, CR LF
  function automatic bq_t build_msg(input logic [31:0] v);
    bq_t q;
    q = {};
`ifdef UART_HEX_PREFIX_EN
    q.push_back(8'h30);
    q.push_back(8'h78);
`endif
    for (int i = NDIG - 1; i >= 0; i--) begin
      int n;
      n = int'((v >> (4 * i)) & 32'hF);
      q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic check_q(input string name, input bq_t act, input bq_t exp);
    check({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", name, i), (i < act.size()) ? {24'h0, act[i]} : 32'hFFFF_FFFF,
            {24'h0, exp[i]});
  endtask

  // Reference model: expected outputs for the current cycle plus remaining bytes
  bq_t        m_q;
  logic       m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0;
  logic [7:0] m_data = 8'h00;
  bq_t        rx_log;

  always @(negedge clk) begin
    logic x;
    if (!rst_n) begin
      m_q = {};
      m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_data = 8'h00;
    end
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("tx_valid", tx_valid, m_valid);
    if (m_valid || !rst_n) check("tx_data", tx_data, m_data);
    if (rst_n && tx_valid && tx_ready) rx_log.push_back(tx_data);
    if (rst_n) begin
      x = m_valid && tx_ready;
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (!m_busy && start) begin
        m_q = build_msg(value);
        m_data = m_q.pop_front();
        m_valid = 1'b1;
        m_busy = 1'b1;
      end else if (x) begin
        if (m_q.size() > 0) m_data = m_q.pop_front();
        else begin
          m_valid = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  // tx_ready pattern: 0 always high, 1 one pulse per 104 cycles, 2 random, 3 always low
  int rdy_mode = 3;
  int cyc = 0;
  always @(posedge clk) begin
    cyc++;
    #2;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = (cyc % 104 == 0);
      2: tx_ready = ($urandom_range(0, 3) != 0);
      default: tx_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [31:0] v);
    @(posedge clk); #2;
    start = 1'b1;
    value = v;
    @(posedge clk); #2;
    start = 1'b0;
    value = $urandom;
  endtask

  task automatic wait_done(input int max, input string name, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    while (cycles < max && !seen) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, {31'h0, seen}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t pfx, body, lit_dead, lit_zero, lit_abc;
    int cyc_n;
    logic [31:0] v;

`ifdef UART_HEX_PREFIX_EN
    pfx = '{8'h30, 8'h78};
`else
    pfx = {};
`endif
    body = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    lit_dead = {pfx, body};
    body = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    lit_zero = {pfx, body};
    body = '{8'h30, 8'h30, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A};
    lit_abc = {pfx, body};

    check_q("model_dead", build_msg(32'hDEADBEEF), lit_dead);
    check_q("model_zero", build_msg(32'h0), lit_zero);
    check_q("model_abc", build_msg(32'h00ABCDEF), lit_abc);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    #1 rst_n = 1'b1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    rx_log = {};
    send(32'hDEADBEEF);
    wait_done(100, "dead_fast", cyc_n);
    check("dead_fast_latency", cyc_n, lit_dead.size() + 1);
    check_q("dead_fast", rx_log, lit_dead);

    rdy_mode = 1;
    rx_log = {};
    send(32'hDEADBEEF);
    wait_done(3000, "dead_bp", cyc_n);
    check_q("dead_bp", rx_log, lit_dead);

    rdy_mode = 0;
    repeat (2) @(posedge clk);
    rx_log = {};
    send(32'h0);
    wait_done(100, "zero", cyc_n);
    check("zero_latency", cyc_n, lit_zero.size() + 1);
    check_q("zero", rx_log, lit_zero);
    rx_log = {};
    send(32'h00ABCDEF);
    wait_done(100, "abc", cyc_n);
    check_q("abc", rx_log, lit_abc);

    rdy_mode = 2;
    rx_log = {};
    send(32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #2 start = 1'b1; value = 32'h12345678;
    @(posedge clk); #2 start = 1'b0;
    check("restart_busy", busy, 1);
    wait_done(500, "restart", cyc_n);
    check_q("restart", rx_log, lit_dead);

    rdy_mode = 0;
    repeat (2) @(posedge clk);
    send(32'hDEADBEEF);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rx_log = {};
    send(32'hCAFEF00D);
    wait_done(100, "after_rst", cyc_n);
    check_q("after_rst", rx_log, build_msg(32'hCAFEF00D));

    for (int it = 0; it < 25; it++) begin
      rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      rx_log = {};
      v = $urandom;
      send(v);
      if ($urandom_range(0, 1) == 1) begin
        #1 start = 1'b1; value = $urandom;
        @(posedge clk); #2 start = 1'b0;
      end
      wait_done(1000, $sformatf("rand%0d", it), cyc_n);
      check_q($sformatf("rand%0d", it), rx_log, build_msg(v));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
